// File: rtl/dmem_wait_ctrl.sv
// Data-memory wait-state controller: turns single-cycle core loads/stores into
// req/ack transfers on a slow word-wide memory, with read-modify-write byte stores.
module dmem_wait_ctrl #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic              cpu_sb,
  input  logic [31:0]       cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  stall_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic [31:0]        cpu_rdata_q, cpu_rdata_d;
  logic [7:0]         sb_byte_q, sb_byte_d;
  logic [1:0]         lane_q, lane_d;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;
  logic               stall_c;
  logic [31:0]        merged_c;
  logic               unused_addr_bits;

  // Address bits above the backing memory wrap and are intentionally dropped.
  assign unused_addr_bits = ^cpu_addr[31:ADDR_W+2];

  // Big-endian byte lane insertion into the word read back during RMW.
  always_comb begin
    merged_c = mem_rdata;
    case (lane_q)
      2'd0:    merged_c[31:24] = sb_byte_q;
      2'd1:    merged_c[23:16] = sb_byte_q;
      2'd2:    merged_c[15:8]  = sb_byte_q;
      default: merged_c[7:0]   = sb_byte_q;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    mem_addr_d     = mem_addr_q;
    mem_wdata_d    = mem_wdata_q;
    cpu_rdata_d    = cpu_rdata_q;
    sb_byte_d      = sb_byte_q;
    lane_d         = lane_q;
    stall_cycles_d = stall_cycles_q;
    stall_c        = 1'b0;

    case (state_q)
      S_IDLE: begin
        stall_c = cpu_re | cpu_we;
        if (cpu_re | cpu_we) begin
          mem_addr_d  = cpu_addr[ADDR_W+1:2];
          lane_d      = cpu_addr[1:0];
          sb_byte_d   = cpu_wdata[7:0];
          mem_wdata_d = cpu_wdata;
          if (cpu_we) state_d = cpu_sb ? S_RMW_RD : S_WR;
          else        state_d = S_RD;
        end
      end
      S_RD: begin
        stall_c = 1'b1;
        if (mem_ack) begin
          cpu_rdata_d = mem_rdata;
          state_d     = S_DONE;
        end
      end
      S_WR: begin
        stall_c = 1'b1;
        if (mem_ack) state_d = S_DONE;
      end
      S_RMW_RD: begin
        stall_c = 1'b1;
        if (mem_ack) begin
          mem_wdata_d = merged_c;
          state_d     = S_RMW_WR;
        end
      end
      S_RMW_WR: begin
        stall_c = 1'b1;
        if (mem_ack) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Request strobes are Moore outputs of the state being entered.
    mem_req_d = (state_d == S_RD) || (state_d == S_WR) ||
                (state_d == S_RMW_RD) || (state_d == S_RMW_WR);
    mem_we_d  = (state_d == S_WR) || (state_d == S_RMW_WR);

    if (stall_c && (stall_cycles_q != {CNT_W{1'b1}}))
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      cpu_rdata_q    <= '0;
      sb_byte_q      <= '0;
      lane_q         <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      cpu_rdata_q    <= cpu_rdata_d;
      sb_byte_q      <= sb_byte_d;
      lane_q         <= lane_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign cpu_stall    = stall_c;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign cpu_rdata    = cpu_rdata_q;
  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// Bench for dmem_wait_ctrl: random loads/stores against a word-array memory
// model with random ack delays, plus directed byte-store, reset and saturation cases.
module tb_dmem_wait_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_re, cpu_we, cpu_sb;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic        mem_ack;
  logic [15:0] stall_cycles;

  logic [31:0] d4_unused_rdata, d4_unused_wdata;
  logic        d4_unused_stall, d4_unused_req, d4_unused_we;
  logic [5:0]  d4_unused_addr;
  logic [3:0]  stall_cycles4;

  always #5 clk = ~clk;

  dmem_wait_ctrl u_dut (
    .clk(clk), .reset(reset), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_sb(cpu_sb),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_stall(cpu_stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall_cycles(stall_cycles)
  );

  dmem_wait_ctrl #(.ADDR_W(6), .CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_sb(cpu_sb),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(d4_unused_rdata),
    .cpu_stall(d4_unused_stall), .mem_req(d4_unused_req), .mem_we(d4_unused_we),
    .mem_addr(d4_unused_addr), .mem_wdata(d4_unused_wdata), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .stall_cycles(stall_cycles4)
  );

  logic [31:0] bkmem   [64];
  logic [31:0] ref_mem [64];
  int checks = 0, errors = 0;
  int waits = 0, reads = 0, writes = 0;
  int fixed_wait = -1, wait_left = 0;
  int total_stall = 0, exp_addr = 0;
  bit hold_ack = 1'b0, stray_en = 1'b0, in_done = 1'b0, req_active = 1'b0;
  logic [5:0]  sv_addr;
  logic        sv_we;
  logic [31:0] sv_wdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int next_wait();
    return (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
  endfunction

  // Backing memory: acks after a chosen number of wait cycles, drives junk otherwise.
  initial begin
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack   = 1'b0;
      mem_rdata = $urandom;
      if (reset) begin
        wait_left  = next_wait();
        req_active = 1'b0;
      end else if (mem_req) begin
        if (req_active) begin
          check("req_addr_stable", 32'(mem_addr), 32'(sv_addr));
          check("req_we_stable", 32'(mem_we), 32'(sv_we));
          if (mem_we) check("req_wdata_stable", mem_wdata, sv_wdata);
        end else begin
          sv_addr  = mem_addr;
          sv_we    = mem_we;
          sv_wdata = mem_wdata;
          check("req_addr", 32'(mem_addr), 32'(exp_addr));
        end
        if (!hold_ack && wait_left == 0) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            bkmem[mem_addr] = mem_wdata;
            writes++;
          end else begin
            mem_rdata = bkmem[mem_addr];
            reads++;
          end
          req_active = 1'b0;
          wait_left  = next_wait();
        end else begin
          waits++;
          if (!hold_ack) wait_left--;
          req_active = 1'b1;
        end
      end else begin
        req_active = 1'b0;
        if (stray_en && $urandom_range(0, 3) == 0) mem_ack = 1'b1;
      end
    end
  end

  task automatic do_op(input bit re, input bit we, input bit sb,
                       input logic [31:0] addr, input logic [31:0] wdata);
    int idx, cyc, w0, r0, wr0, nacc, sh, exp_len;
    idx      = int'(addr[7:2]);
    exp_addr = idx;
    cpu_re = re; cpu_we = we; cpu_sb = sb; cpu_addr = addr; cpu_wdata = wdata;
    #1;
    if (in_done) begin
      @(negedge clk);
      #1;
    end
    w0 = waits; r0 = reads; wr0 = writes; cyc = 0;
    while (cpu_stall && cyc < 200) begin
      cyc++;
      @(negedge clk);
      #1;
    end
    if (!(re || we)) begin
      check("idle_no_stall", 32'(cyc), 32'd0);
      in_done = 1'b0;
      return;
    end
    in_done = 1'b1;
    nacc    = (we && sb) ? 2 : 1;
    exp_len = 1 + nacc + (waits - w0);
    check("stall_len", 32'(cyc), 32'(exp_len));
    check("read_count", 32'(reads - r0), (we && !sb) ? 32'd0 : 32'd1);
    check("write_count", 32'(writes - wr0), we ? 32'd1 : 32'd0);
    if (we) begin
      if (sb) begin
        sh = (3 - int'(addr[1:0])) * 8;
        ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << sh)) | ({24'd0, wdata[7:0]} << sh);
      end else begin
        ref_mem[idx] = wdata;
      end
      check("mem_word", bkmem[idx], ref_mem[idx]);
    end else begin
      check("load_data", cpu_rdata, ref_mem[idx]);
    end
    total_stall += exp_len;
    check("stall_cycles", 32'(stall_cycles), 32'(total_stall));
    check("stall_sat4", 32'(stall_cycles4), (total_stall > 15) ? 32'd15 : 32'(total_stall));
  endtask

  initial begin
    int n;
    reset = 1'b1;
    cpu_re = 1'b0; cpu_we = 1'b0; cpu_sb = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 64; i++) begin
      bkmem[i]   = $urandom;
      ref_mem[i] = bkmem[i];
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    check("rst_rdata", cpu_rdata, 32'd0);
    check("rst_cnt", 32'(stall_cycles), 32'd0);

    // Directed: LW with immediate ack, delayed SW, both byte-store lanes of interest.
    bkmem[2] = 32'hDEADBEEF; ref_mem[2] = 32'hDEADBEEF;
    fixed_wait = 0; wait_left = 0;
    do_op(1'b1, 1'b0, 1'b0, 32'h8, 32'h0);
    check("lw_deadbeef", cpu_rdata, 32'hDEADBEEF);
    check("lw_stall_cnt", 32'(stall_cycles), 32'd2);
    fixed_wait = 3; wait_left = 3;
    do_op(1'b0, 1'b1, 1'b0, 32'h4, 32'h11223344);
    fixed_wait = 0; wait_left = 0;
    do_op(1'b0, 1'b1, 1'b1, 32'h6, 32'h000000AB);
    check("sb_lane2", bkmem[1], 32'h1122AB44);
    bkmem[1] = 32'h0; ref_mem[1] = 32'h0;
    do_op(1'b0, 1'b1, 1'b1, 32'h7, 32'hFFFFFFAB);
    check("sb_lane3", bkmem[1], 32'h000000AB);

    // Random back-to-back traffic with random waits and stray acks.
    fixed_wait = -1; stray_en = 1'b1;
    for (int k = 0; k < 250; k++) begin
      n = int'($urandom_range(0, 9));
      if (n < 3)      do_op(1'b1, 1'b0, 1'b0, $urandom, $urandom);
      else if (n < 5) do_op(1'b0, 1'b1, 1'b0, $urandom, $urandom);
      else if (n < 7) do_op(1'b0, 1'b1, 1'b1, $urandom, $urandom);
      else if (n < 8) do_op(1'b1, 1'b1, n[0], $urandom, $urandom);
      else            do_op(1'b0, 1'b0, 1'b0, $urandom, $urandom);
    end

    // Reset while the write half of a byte store is waiting for its ack.
    fixed_wait = 50; wait_left = 0; exp_addr = 4;
    cpu_re = 1'b0; cpu_we = 1'b1; cpu_sb = 1'b1; cpu_addr = 32'h12; cpu_wdata = 32'h5A;
    n = 0;
    while (!(mem_req && mem_we) && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("rmw_wr_reached", 32'(mem_req && mem_we), 32'd1);
    @(negedge clk);
    reset = 1'b1; cpu_we = 1'b0; cpu_sb = 1'b0;
    #1;
    check("mid_rst_req", 32'(mem_req), 32'd0);
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_addr", 32'(mem_addr), 32'd0);
    check("mid_rst_wdata", mem_wdata, 32'd0);
    check("mid_rst_rdata", cpu_rdata, 32'd0);
    check("mid_rst_cnt", 32'(stall_cycles), 32'd0);
    check("mid_rst_stall", 32'(cpu_stall), 32'd0);
    @(negedge clk);
    reset = 1'b0; fixed_wait = -1; in_done = 1'b0; total_stall = 0;
    check("rmw_abort_mem", bkmem[4], ref_mem[4]);
    do_op(1'b1, 1'b0, 1'b0, 32'h10, 32'h0);
    for (int k = 0; k < 6; k++) do_op(1'b1, 1'b0, 1'b0, $urandom, 32'h0);
    check("sat_final", 32'(stall_cycles4), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
